// File: rtl/stream_bridge_fifo.sv
// Valid-only write stream to valid/ready read stream bridge with FWFT output register.
// Define STREAM_BRIDGE_STATS_EN to add peak_level / stall_cycles / drop_count outputs.
module stream_bridge_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024,
  parameter int AF_THRESH  = DEPTH - 16,
  parameter int FRAME_LEN  = 36,
  parameter int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  almost_full,
  output logic                  full,
  output logic                  overflow,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready_in,
  output logic                  frame_last,
  output logic [15:0]           frames_done,
`ifdef STREAM_BRIDGE_STATS_EN
  output logic [LVL_W-1:0]      peak_level,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           drop_count,
`endif
  output logic [LVL_W-1:0]      level
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_END = BEAT_W'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0]       wr_ptr, rd_ptr;
  logic [BEAT_W-1:0]     beat;
  logic [LVL_W-1:0]      level_nxt;
  logic                  wr_en, drop, pop, mem_empty, load;

  assign full        = (level == LVL_W'(DEPTH));
  assign almost_full = (level >= LVL_W'(AF_THRESH));
  assign wr_en       = valid_in && !full && !flush;
  assign drop        = valid_in &&  full && !flush;
  assign pop         = valid_out && ready_in;
  // level counts the output register too, so memory is empty when only it remains
  assign mem_empty   = (level == LVL_W'(valid_out));
  assign load        = (!valid_out || pop) && !mem_empty;
  assign frame_last  = valid_out && (beat == BEAT_END);

  always_comb begin
    level_nxt = level;
    case ({wr_en, pop})
      2'b10:   level_nxt = level + LVL_ONE;
      2'b01:   level_nxt = level - LVL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      beat        <= '0;
      frames_done <= '0;
      overflow    <= 1'b0;
      level       <= '0;
    end else if (flush) begin
      // frames_done intentionally survives a flush
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      beat      <= '0;
      overflow  <= 1'b0;
      level     <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (load) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        data_out  <= mem[rd_ptr[ADDR_W-1:0]];
        valid_out <= 1'b1;
      end else if (pop) begin
        valid_out <= 1'b0;
      end
      if (pop) begin
        if (frame_last) begin
          beat        <= '0;
          frames_done <= frames_done + 16'd1;
        end else begin
          beat <= beat + BEAT_ONE;
        end
      end
      if (drop) overflow <= 1'b1;
      level <= level_nxt;
    end
  end

`ifdef STREAM_BRIDGE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_level   <= '0;
      stall_cycles <= '0;
      drop_count   <= '0;
    end else if (flush) begin
      peak_level   <= '0;
      stall_cycles <= '0;
      drop_count   <= '0;
    end else begin
      if (level_nxt > peak_level) peak_level <= level_nxt;
      if (valid_out && !ready_in && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stream_bridge_fifo.sv
// Directed bench for stream_bridge_fifo (DEPTH=8); stats checks only when STREAM_BRIDGE_STATS_EN is defined.
module tb_stream_bridge_fifo;
  localparam int DW = 16, DEP = 8, AF = 6, FL = 36, LW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, valid_in, ready_in;
  logic [DW-1:0] data_in;
  logic          almost_full, full, overflow, valid_out, frame_last;
  logic [DW-1:0] data_out;
  logic [15:0]   frames_done;
  logic [LW-1:0] level;
`ifdef STREAM_BRIDGE_STATS_EN
  logic [LW-1:0] peak_level;
  logic [31:0]   stall_cycles;
  logic [15:0]   drop_count;
`endif

  stream_bridge_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .AF_THRESH(AF), .FRAME_LEN(FL), .LVL_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .valid_in(valid_in), .data_in(data_in),
    .almost_full(almost_full), .full(full), .overflow(overflow), .valid_out(valid_out),
    .data_out(data_out), .ready_in(ready_in), .frame_last(frame_last), .frames_done(frames_done),
`ifdef STREAM_BRIDGE_STATS_EN
    .peak_level(peak_level), .stall_cycles(stall_cycles), .drop_count(drop_count),
`endif
    .level(level)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; valid_in = 1'b0; cyc(); flush = 1'b0;
  endtask

  task automatic write_n(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1; data_in = base + DW'(i); cyc();
    end
    valid_in = 1'b0;
  endtask

  // full frame with ready held high; beat assumed 0 on entry
  task automatic pass_frame(input logic [DW-1:0] base, input logic [15:0] frames_exp);
    ready_in = 1'b1;
    for (int i = 0; i < FL; i++) begin
      valid_in = 1'b1; data_in = base + DW'(i); cyc();
      if (i > 0) begin
        chk("pt_vld", valid_out, 1);
        chk("pt_data", data_out, base + DW'(i - 1));
        chk("pt_last", frame_last, 0);
      end
    end
    valid_in = 1'b0; cyc();
    chk("pt_data_end", data_out, base + DW'(FL - 1));
    chk("pt_last_end", frame_last, 1);
    cyc();
    chk("pt_frames", frames_done, frames_exp);
    chk("pt_level0", level, 0);
    chk("pt_vld0", valid_out, 0);
  endtask

  // reference model for the random phase
  logic [DW-1:0] q[$];
  int  lvl_m, beat_m, frames_m, peak_m, stall_m, drop_m;
  bit  ov_m;

  task automatic rnd_step(input bit vin, input bit rdy, input logic [DW-1:0] d);
    bit pop_m, acc, drp;
    int mem_m;
    valid_in = vin; data_in = d; ready_in = rdy;
    pop_m = ov_m && rdy;
    acc   = vin && (lvl_m != DEP);
    drp   = vin && (lvl_m == DEP);
    mem_m = lvl_m - int'(ov_m);
    if (ov_m && !rdy) stall_m++;
    if (drp) drop_m++;
    if (pop_m) begin
      void'(q.pop_front());
      if (beat_m == FL - 1) begin beat_m = 0; frames_m++; end
      else beat_m++;
    end
    if (acc) q.push_back(d);
    ov_m  = (ov_m && !pop_m) ? 1'b1 : (mem_m > 0);
    lvl_m = lvl_m + int'(acc) - int'(pop_m);
    if (lvl_m > peak_m) peak_m = lvl_m;
    cyc();
    chk("rw_vld", valid_out, ov_m);
    if (ov_m) chk("rw_data", data_out, q[0]);
    chk("rw_level", level, lvl_m);
    chk("rw_last", frame_last, ov_m && (beat_m == FL - 1));
    chk("rw_frames", frames_done, frames_m);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = '0;
    #12;
    chk("rst_vld", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_level", level, 0);
    chk("rst_full", full, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_frames", frames_done, 0);
    chk("rst_last", frame_last, 0);
    @(negedge clk); rst_n = 1'b1; cyc();

    // pass-through of one full frame
    pass_frame(16'h0001, 16'd1);

    // backpressure hold and almost_full
    do_flush();
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in = 1'b1; data_in = 16'h0010 + 16'(i); cyc();
      if (i == 4) begin chk("bp_af_lo", almost_full, 0); chk("bp_lvl5", level, 5); end
    end
    valid_in = 1'b0;
    chk("bp_lvl6", level, 6);
    chk("bp_af_hi", almost_full, 1);
    chk("bp_full", full, 0);
    chk("bp_vld", valid_out, 1);
    chk("bp_head", data_out, 16'h0010);
    cyc(); cyc();
    chk("bp_hold", data_out, 16'h0010);
    chk("bp_hold_last", frame_last, 0);
    ready_in = 1'b1;
    for (int j = 0; j < 6; j++) begin
      chk("bp_drain", data_out, 16'h0010 + 16'(j)); cyc();
    end
    chk("bp_empty_vld", valid_out, 0);
    chk("bp_empty_lvl", level, 0);

    // overflow with sticky flag
    do_flush();
    ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1; data_in = 16'h0021 + 16'(i); cyc();
      if (i == 7) begin
        chk("of_full", full, 1); chk("of_lvl8", level, 8); chk("of_pre", overflow, 0);
      end
    end
    valid_in = 1'b0;
    chk("of_set", overflow, 1);
    chk("of_lvl", level, 8);
    chk("of_head", data_out, 16'h0021);
    ready_in = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("of_drain", data_out, 16'h0021 + 16'(j)); cyc();
    end
    chk("of_empty", valid_out, 0);
    chk("of_lvl0", level, 0);
    chk("of_sticky", overflow, 1);

    // write+pop while full: write dropped
    do_flush();
    chk("fl_ovf_clr", overflow, 0);
    chk("fl_lvl", level, 0);
    chk("fl_frames", frames_done, 1);
    ready_in = 1'b0;
    write_n(8, 16'h0031);
    chk("wp_full", full, 1);
    valid_in = 1'b1; data_in = 16'h0099; ready_in = 1'b1; cyc();
    valid_in = 1'b0;
    chk("wp_ovf", overflow, 1);
    chk("wp_lvl", level, 7);
    chk("wp_head", data_out, 16'h0032);
    for (int j = 1; j < 8; j++) begin
      chk("wp_drain", data_out, 16'h0031 + 16'(j)); cyc();
    end
    chk("wp_empty", valid_out, 0);

    // flush mid-frame (overflow still set from above)
    ready_in = 1'b1;
    write_n(11, 16'h0041);
    cyc();
    chk("mf_head", data_out, 16'h004B);
    chk("mf_ovf_pre", overflow, 1);
    flush = 1'b1; valid_in = 1'b1; data_in = 16'h00EE; cyc();
    flush = 1'b0; valid_in = 1'b0;
    chk("mf_vld", valid_out, 0);
    chk("mf_lvl", level, 0);
    chk("mf_ovf", overflow, 0);
    chk("mf_frames", frames_done, 1);
    cyc();
    chk("mf_discard", level, 0);
    pass_frame(16'h0100, 16'd2);

    // asynchronous reset mid-stream
    ready_in = 1'b0;
    write_n(3, 16'h0051);
    chk("ar_pre_lvl", level, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", valid_out, 0);
    chk("ar_data", data_out, 0);
    chk("ar_lvl", level, 0);
    chk("ar_full", full, 0);
    chk("ar_af", almost_full, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_frames", frames_done, 0);
    chk("ar_last", frame_last, 0);
`ifdef STREAM_BRIDGE_STATS_EN
    chk("ar_peak", peak_level, 0);
    chk("ar_stall", stall_cycles, 0);
    chk("ar_drop", drop_count, 0);
`endif
    @(negedge clk); rst_n = 1'b1; cyc();

    // random ready_in across pointer wrap
    do_flush();
    q.delete();
    lvl_m = 0; ov_m = 1'b0; beat_m = 0; frames_m = 0; peak_m = 0; stall_m = 0; drop_m = 0;
    begin
      int sent = 0;
      int budget = 0;
      while (sent < 100 && budget < 2000) begin
        bit vin;
        vin = ($urandom_range(0, 3) != 0);
        rnd_step(vin, 1'($urandom_range(0, 1)), 16'h0200 + 16'(sent));
        if (vin) sent++;
        budget++;
      end
      chk("rw_budget", (budget < 2000), 1);
      budget = 0;
      while (lvl_m != 0 && budget < 40) begin
        rnd_step(1'b0, 1'b1, 16'h0000);
        budget++;
      end
      chk("rw_drained", level, 0);
    end
`ifdef STREAM_BRIDGE_STATS_EN
    chk("st_peak", peak_level, peak_m);
    chk("st_stall", stall_cycles, stall_m);
    chk("st_drop", drop_count, drop_m);
    do_flush();
    chk("st_peak_clr", peak_level, 0);
    chk("st_stall_clr", stall_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_bridge_fifo.md
Name: stream_bridge_fifo

Overview:
- Parametrised inter-layer stream buffer for the generator datapath. It replaces the hand-written FIFO-plus-read-FSM bridges that sit between encoder and decoder stages.
- Write side is a valid-only layer stream, since conv/activation layers cannot be stalled. Read side is a valid/ready handshake into a stallable consumer such as a transposed-conv layer.
- Adds an upstream almost-full warning, sticky overflow detection, frame-boundary marking, flush, and optional occupancy statistics.

Parameters:
- DATA_WIDTH, 16, sample width (signed Q-format, passed through untouched)
- DEPTH, 1024, total capacity in samples, including the output register; power of 2, at least 4
- AF_THRESH, DEPTH-16, level at or above which almost_full asserts
- FRAME_LEN, 36, samples per feature map (e.g. 6x6), used for frame_last; at least 1
- LVL_W, $clog2(DEPTH)+1, width of the level port (derived)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of contents
- valid_in  in  1  write strobe; one sample per cycle
- data_in  in  DATA_WIDTH  write data
- almost_full  out  1  level >= AF_THRESH (combinational from registered level)
- full  out  1  level == DEPTH
- overflow  out  1  sticky; a write was dropped
- valid_out  out  1  output register holds a sample
- data_out  out  DATA_WIDTH  sample at head of stream
- ready_in  in  1  consumer accepts data_out this cycle
- frame_last  out  1  valid_out and the head sample is the last of its frame
- frames_done  out  16  count of completed output frames, wraps
- level  out  LVL_W  samples held (memory plus output register)

Behaviour:
- Reset (async, rst_n=0) clears pointers and beat counter. Outputs: valid_out=0, data_out=0, overflow=0, frames_done=0, level=0, full=0, almost_full=0, frame_last=0.
- Storage: DEPTH-entry memory with ADDR_W+1-bit wr/rd pointers, plus a one-entry first-word-fall-through output register.
- Write: accepted iff valid_in && !full && !flush. A write while full is dropped even if a pop happens in the same cycle; it sets overflow, which stays high until rst_n or flush.
- Output register loads from memory head when it is empty, or when it is being popped (valid_out && ready_in) and memory is non-empty. Otherwise valid_out falls to 0 after a pop.
- Empty pass-through: when the bridge is empty, a sample written at edge k is visible on valid_out/data_out after edge k+1 (1-cycle latency). Upstream never sees backpressure.
- Hold rule: while valid_out && !ready_in, data_out and frame_last are held stable.
- Sustained throughput: 1 sample/cycle with ready_in held high and no bubbles once primed.
- level update:
  - +1 on accepted write, -1 on pop, unchanged when both occur.
  - Bounded to 0..DEPTH.
  - full and almost_full derive from the registered level.
- Frame tracking:
  - beat counter (0..FRAME_LEN-1) advances on each pop.
  - frame_last = valid_out && beat==FRAME_LEN-1.
  - A pop with frame_last wraps beat to 0 and increments frames_done (modulo 2^16).
- flush (sync) empties pointers, output register, beat and level, and clears overflow. A write in the same cycle is discarded. frames_done is preserved.
- Reset mid-stream discards all contents immediately. There is no partial-frame recovery.
- Pointer wrap at DEPTH is natural binary rollover of the ADDR_W low bits. Full/empty are taken from level, not pointer MSB compare.

Optional Feature:
- Macro: STREAM_BRIDGE_STATS_EN.
- With it defined, three extra outputs are added:
  - peak_level (LVL_W): high-water mark of level.
  - stall_cycles (32): counts cycles with valid_out && !ready_in, saturating at all-ones.
  - drop_count (16): counts dropped writes, saturating.
- All three reset to 0 on rst_n and clear on flush.
- Without the macro, these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Pass-through: ready_in=1, write 0x0001..0x0024 (36 samples) back-to-back. Expected: identical sequence out with 1-cycle latency; frame_last only on 0x0024; frames_done=1; level returns to 0.
- Backpressure hold: DEPTH=8, AF_THRESH=6, ready_in=0, write 6 samples. Expected: almost_full=1 at level=6; valid_out=1 with data_out frozen at the first sample; then ready_in=1 drains in order.
- Overflow: DEPTH=8, ready_in=0, write 10 samples. Expected: full=1 at level=8; samples 9-10 dropped; overflow=1 sticky; draining yields exactly samples 1-8.
- Simultaneous write+pop when full: level=8, valid_in=1 and ready_in=1 in one cycle. Expected: write dropped, overflow=1, level=7.
- Flush/reset mid-frame: pop 10 of 36, assert flush for one cycle. Expected: valid_out=0, level=0, overflow=0, frames_done unchanged; the next 36 writes produce frame_last on the 36th. Repeat with rst_n pulsed low mid-stream: frames_done=0 and all outputs at reset values asynchronously.
- Wrap and stats (macro defined): DEPTH=8, stream 100 samples with random ready_in. Expected: data order preserved across pointer wrap; peak_level matches the model; stall_cycles equals the counted valid&&!ready cycles.
